// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and byte-lane helpers for the memory port arbiter
package mips_mem_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
    typedef enum logic {OWN_I, OWN_D} owner_e;
    localparam logic [3:0] BE_NONE = 4'h0;
    localparam logic [3:0] BE_WORD = 4'hF;
    localparam int LANE_W = 8;
    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction
endpackage

// File: rtl/mem_byte_format.sv
// mem_byte_format: little-endian byte-lane steering for stores and extension for loads
module mem_byte_format
    import mips_mem_pkg::*;
(
    input  logic [1:0]  wr_lane_i,
    input  logic        wr_byte_i,
    input  logic        wr_we_i,
    input  logic [31:0] wr_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic [1:0]  rd_lane_i,
    input  logic        rd_byte_i,
    input  logic        rd_sext_i,
    input  logic [31:0] rd_data_i,
    output logic [31:0] rd_data_o
);
    logic [7:0] rbyte;
    always_comb begin
        be_o = !wr_we_i ? BE_NONE : wr_byte_i ? lane_be(wr_lane_i) : BE_WORD;
        wdata_o = wr_byte_i ? {4{wr_data_i[LANE_W-1:0]}} : wr_data_i;
        rbyte = 8'(rd_data_i >> {rd_lane_i, 3'b000});
        rd_data_o = !rd_byte_i ? rd_data_i : {{24{rd_sext_i & rbyte[7]}}, rbyte};
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences one single-ported memory between I-fetch and D-side accesses
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_done,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic              d_signextend,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    output logic              d_err,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);
    state_e            state_q, state_d;
    owner_e            owner_q;
    logic [ADDR_W-1:0] mem_addr_q, sel_addr;
    logic              mem_we_q, byte_q, sext_q;
    logic [3:0]        mem_be_q, fmt_be;
    logic [31:0]       mem_wdata_q, fmt_wdata, fmt_rdata;
    logic [1:0]        lane_q;
    logic              i_done_q, d_done_q, d_err_q;
    logic [31:0]       i_rdata_q, d_rdata_q;
    logic              misaligned, start, enter_done;

    assign misaligned = d_req & ~d_byte & (d_addr[1:0] != 2'b00);
    assign start      = (state_q == IDLE) & (d_req | i_req) & ~misaligned;
    assign sel_addr   = d_req ? d_addr : i_addr;
    assign enter_done = (state_q != DONE) & (state_d == DONE);

    mem_byte_format u_fmt (
        .wr_lane_i (d_addr[1:0]),
        .wr_byte_i (d_byte),
        .wr_we_i   (d_we),
        .wr_data_i (d_wdata),
        .be_o      (fmt_be),
        .wdata_o   (fmt_wdata),
        .rd_lane_i (lane_q),
        .rd_byte_i (byte_q),
        .rd_sext_i (sext_q),
        .rd_data_i (mem_rdata),
        .rd_data_o (fmt_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = misaligned ? DONE : (d_req | i_req) ? ISSUE : IDLE;
            ISSUE:   state_d = !mem_ready ? ISSUE : mem_we_q ? DONE : WAIT;
            WAIT:    state_d = mem_rvalid ? DONE : WAIT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= OWN_I;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= BE_NONE;
            mem_wdata_q <= '0;
            lane_q      <= '0;
            byte_q      <= 1'b0;
            sext_q      <= 1'b0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            d_err_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            if (start) begin
                owner_q     <= d_req ? OWN_D : OWN_I;
                mem_addr_q  <= {sel_addr[ADDR_W-1:2], 2'b00};
                mem_we_q    <= d_req & d_we;
                mem_be_q    <= d_req ? fmt_be : BE_NONE;
                mem_wdata_q <= (d_req & d_we) ? fmt_wdata : '0;
                lane_q      <= sel_addr[1:0];
                byte_q      <= d_req & d_byte;
                sext_q      <= d_signextend;
            end
            // A misaligned access completes from IDLE, so ownership is implicitly D.
            i_done_q <= enter_done & (state_q != IDLE) & (owner_q == OWN_I);
            d_done_q <= enter_done & ((state_q == IDLE) | (owner_q == OWN_D));
            d_err_q  <= enter_done & (state_q == IDLE);
            if (state_q == IDLE && misaligned) d_rdata_q <= '0;
            if (state_q == WAIT && mem_rvalid) begin
                if (owner_q == OWN_I) i_rdata_q <= mem_rdata;
                else                  d_rdata_q <= fmt_rdata;
            end
        end
    end

    always_comb begin
        mem_req   = state_q == ISSUE;
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_be    = mem_be_q;
        mem_wdata = mem_wdata_q;
        i_done    = i_done_q;
        i_rdata   = i_rdata_q;
        i_stall   = i_req & ~i_done_q;
        d_done    = d_done_q;
        d_rdata   = d_rdata_q;
        d_err     = d_err_q;
        d_stall   = d_req & ~d_done_q;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors plus contention and reset sequences for mem_port_arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, i_done, i_stall;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_byte, d_signextend, d_done, d_err, d_stall;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ready, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic        is_d, we, byt, sext;
        logic [31:0] addr, wdata, rdata;
        int          rw, vw;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata, e_rdata;
        logic        e_err;
        int          e_cyc;
    } vec_t;

    vec_t vt[12];

    mem_port_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_signextend(d_signextend),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
        .d_err(d_err), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int idx);
        int  acc = -1;
        int  nreq = 0;
        bit  seen = 0;
        @(posedge clk); #1;
        d_req = v.is_d; i_req = !v.is_d;
        d_we = v.we; d_byte = v.byt; d_signextend = v.sext;
        d_addr = v.addr; i_addr = v.addr; d_wdata = v.wdata;
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            @(negedge clk);
            mem_ready  = mem_req && nreq >= v.rw;
            mem_rvalid = !v.we && acc >= 0 && cyc == acc + 1 + v.vw;
            mem_rdata  = mem_rvalid ? v.rdata : 32'h0BAD_0BAD;
            if (mem_req) begin
                nreq++;
                chk($sformatf("v%0d mem_addr", idx), mem_addr, v.e_addr);
                chk($sformatf("v%0d mem_be", idx), {28'd0, mem_be}, {28'd0, v.e_be});
                chk($sformatf("v%0d mem_we", idx), {31'd0, mem_we}, {31'd0, v.we});
                if (v.we) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.e_wdata);
                if (mem_ready) acc = cyc;
            end
            if (v.is_d) chk($sformatf("v%0d d_stall", idx), {31'd0, d_stall}, {31'd0, !d_done});
            else        chk($sformatf("v%0d i_stall", idx), {31'd0, i_stall}, {31'd0, !i_done});
            if (i_done || d_done) begin
                seen = 1;
                chk($sformatf("v%0d done_cycle", idx), cyc, v.e_cyc);
                chk($sformatf("v%0d owner_done", idx), {30'd0, d_done, i_done}, v.is_d ? 32'd2 : 32'd1);
                chk($sformatf("v%0d rdata", idx), v.is_d ? d_rdata : i_rdata, v.e_rdata);
                chk($sformatf("v%0d d_err", idx), {31'd0, d_err}, {31'd0, v.e_err});
            end
        end
        if (!seen) chk($sformatf("v%0d timeout", idx), 32'd0, 32'd1);
        if (v.e_err) chk($sformatf("v%0d no_mem_req", idx), nreq, 0);
        @(posedge clk); #1;
        d_req = 0; i_req = 0; mem_ready = 0; mem_rvalid = 0;
    endtask

    initial begin
        int  acc, d_cyc, i_cyc, first_addr;
        logic [31:0] acc_addr;
        //            is_d we byt sext addr          wdata          rdata          rw vw e_addr        e_be   e_wdata        e_rdata        err cyc
        vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0,         32'hDEADBEEF, 0, 0, 32'h100, 4'h0, 32'h0,         32'hDEADBEEF, 1'b0, 3};
        vt[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h203, 32'h5A,        32'h0,        0, 0, 32'h200, 4'h8, 32'h5A5A5A5A, 32'h0,        1'b0, 2};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h201, 32'h0,         32'h00008000, 0, 0, 32'h200, 4'h0, 32'h0,         32'hFFFFFF80, 1'b0, 3};
        vt[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h201, 32'h0,         32'h00008000, 0, 0, 32'h200, 4'h0, 32'h0,         32'h00000080, 1'b0, 3};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h0,         32'h12345678, 2, 2, 32'h200, 4'h0, 32'h0,         32'h12345678, 1'b0, 7};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h202, 32'h0,         32'h11111111, 0, 0, 32'h0,   4'h0, 32'h0,         32'h0,        1'b1, 1};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'hCAFEF00D,  32'h0,        1, 0, 32'h300, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0, 3};
        vt[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h303, 32'h0,         32'h7F000000, 0, 0, 32'h300, 4'h0, 32'h0,         32'h0000007F, 1'b0, 3};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0,         32'h000000F0, 0, 0, 32'h300, 4'h0, 32'h0,         32'hFFFFFFF0, 1'b0, 3};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h301, 32'h99,        32'h0,        0, 0, 32'h0,   4'h0, 32'h0,         32'h0,        1'b1, 1};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h10C, 32'h0,         32'hA5A55A5A, 1, 1, 32'h10C, 4'h0, 32'h0,         32'hA5A55A5A, 1'b0, 5};
        vt[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h123456A5,  32'h0,        0, 0, 32'h200, 4'h1, 32'hA5A5A5A5, 32'h0,        1'b0, 2};

        rst_n = 0; i_req = 1; d_req = 0; d_we = 0; d_byte = 0; d_signextend = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst mem_req", {31'd0, mem_req}, 0);
        chk("rst mem_outs", {mem_addr | mem_wdata}, 0);
        chk("rst mem_we_be", {27'd0, mem_we, mem_be}, 0);
        chk("rst dones", {29'd0, i_done, d_done, d_err}, 0);
        chk("rst rdata", i_rdata | d_rdata, 0);
        chk("rst stalls", {30'd0, i_stall, d_stall}, 32'd2);
        i_req = 0;
        @(posedge clk); #1 rst_n = 1;

        for (int k = 0; k < 12; k++) run(vt[k], k);

        // Contention: D load and I fetch in the same IDLE cycle.
        @(posedge clk); #1;
        d_req = 1; d_we = 0; d_byte = 0; d_addr = 32'h200; i_req = 1; i_addr = 32'h104;
        acc = -1; d_cyc = -1; i_cyc = -1; first_addr = -1; acc_addr = 0;
        for (int cyc = 0; cyc < 30 && i_cyc < 0; cyc++) begin
            @(negedge clk);
            mem_ready  = 1;
            mem_rvalid = acc >= 0 && cyc == acc + 1;
            mem_rdata  = !mem_rvalid ? 32'h0BAD_0BAD : acc_addr == 32'h200 ? 32'h11111111 : 32'h22222222;
            if (mem_req) begin
                if (first_addr < 0) first_addr = int'(mem_addr);
                acc = cyc; acc_addr = mem_addr;
            end
            if (d_done) begin
                d_cyc = cyc;
                chk("cont d_rdata", d_rdata, 32'h11111111);
                chk("cont i_stall", {31'd0, i_stall}, 1);
            end
            if (i_done) begin
                i_cyc = cyc;
                chk("cont i_rdata", i_rdata, 32'h22222222);
            end
            @(posedge clk); #1;
            if (d_done) d_req = 0;
        end
        chk("cont first_addr", first_addr, 32'h200);
        chk("cont d_done_cyc", d_cyc, 3);
        chk("cont i_gap", i_cyc - d_cyc, 4);
        i_req = 0; mem_ready = 0; mem_rvalid = 0;

        // Reset in WAIT, then a late rvalid in IDLE, then a clean fetch.
        @(posedge clk); #1;
        i_req = 1; i_addr = 32'h100; mem_ready = 1;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 0; i_req = 0;
        #1;
        chk("rstw mem_req", {31'd0, mem_req}, 0);
        chk("rstw mem_addr", mem_addr, 0);
        chk("rstw dones", {29'd0, i_done, d_done, d_err}, 0);
        @(posedge clk); #1 rst_n = 1; mem_rvalid = 1; mem_rdata = 32'hBADBAD00;
        @(negedge clk);
        chk("late rvalid done", {30'd0, i_done, d_done}, 0);
        @(negedge clk);
        chk("late rvalid req", {31'd0, mem_req}, 0);
        chk("late rvalid rdata", i_rdata, 0);
        mem_ready = 0; mem_rvalid = 0;
        run('{1'b0, 1'b0, 1'b0, 1'b0, 32'h104, 32'h0, 32'h0F0F0F0F, 0, 0, 32'h104, 4'h0, 32'h0, 32'h0F0F0F0F, 1'b0, 3}, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences one single-ported, variable-latency memory shared by instruction fetch (I-side, word reads) and the MEM stage (D-side: LW/LB/LBU/SW/SB). Sits between the 5-stage pipeline and the unified memory. Per access it arbitrates, issues the transaction, handles byte-lane steering and sign extension, and stalls the waiting requester(s). One transaction is outstanding at a time.

## Interface
- `ADDR_W`, default 32: byte address width.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_req` in 1: fetch request; held with `i_addr` until `i_done`.
- `i_addr` in ADDR_W: fetch byte address.
- `i_rdata` out 32: fetched word, valid while `i_done`.
- `i_done` out 1: one-cycle completion pulse.
- `i_stall` out 1: `i_req & ~i_done`, combinational.
- `d_req` in 1: data request; all `d_*` inputs held until `d_done`.
- `d_we` in 1: 1 = store.
- `d_byte` in 1: byte access (LB/LBU/SB).
- `d_signextend` in 1: sign-extend byte loads.
- `d_addr` in ADDR_W: byte address.
- `d_wdata` in 32: store data; SB uses bits [7:0].
- `d_rdata` out 32: load result, aligned and extended, valid while `d_done`.
- `d_done` out 1: one-cycle completion pulse.
- `d_err` out 1: pulses with `d_done` on a misaligned word access.
- `d_stall` out 1: `d_req & ~d_done`, combinational.
- `mem_req` out 1: transaction valid.
- `mem_we` out 1: write.
- `mem_addr` out ADDR_W: word-aligned address, with [1:0] = 0.
- `mem_be` out 4: byte enables for writes.
- `mem_wdata` out 32: write data.
- `mem_ready` in 1: memory accepts in any cycle where `mem_req & mem_ready`.
- `mem_rvalid` in 1: read data valid; arrives 1 or more cycles after acceptance; never for writes.
- `mem_rdata` in 32: read word.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE** samples requests.
  - Fixed priority D over I, because the D-side instruction is older and the pipeline is already stalled on it.
  - A misaligned D word access (`~d_byte & d_addr[1:0]!=0`) goes straight to DONE with `d_err=1`, `d_rdata=0`, and no memory transaction.
  - Otherwise: latch the owner, address and control into registers, then go to ISSUE.
- **ISSUE** drives registered `mem_*` with `mem_req=1` until `mem_ready`.
  - On acceptance, a write goes to DONE and a read goes to WAIT.
- **WAIT** stays until `mem_rvalid`, captures the formatted data, then goes to DONE.
- **DONE** pulses the owner's `*_done` for one cycle (and `d_err` if flagged), then returns to IDLE.
- Byte lanes are little-endian; lane = `addr[1:0]`, and lane 0 is bits [7:0].
  - SB: `mem_be = 1 << lane`; `mem_wdata` = the byte replicated in all 4 lanes.
  - SW: `mem_be = 4'hF`.
  - Reads: `mem_be = 4'h0`.
  - LB/LBU: selected byte, extended per `d_signextend`.
  - LW and fetch: the word unchanged.
- Request inputs are ignored outside IDLE. A requester dropping `*_req` mid-transaction is illegal; the transaction completes regardless.

## Timing
- Reset: state = IDLE. All outputs are 0: `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, `*_done`, `*_rdata`, `d_err`. Stalls follow their combinational equations.
- Reset mid-transaction aborts immediately. A late `mem_rvalid` arriving in IDLE or ISSUE is ignored.
- Zero-wait memory (`mem_ready=1`, `mem_rvalid` the cycle after acceptance), request in cycle 0:
  - Read: `mem_req` in cycle 1, `mem_rvalid` in cycle 2, `*_done` in cycle 3. Latency is 3 cycles.
  - Write: `mem_req` in cycle 1, `d_done` in cycle 2.
  - Misaligned access: `d_done` + `d_err` in cycle 1.
- Each wait cycle of `mem_ready` or `mem_rvalid` adds exactly one cycle.
- Both requests arriving in the same IDLE cycle: D is served first. I is served from the IDLE cycle after D's DONE, so I completes 4 cycles after `d_done` with zero-wait memory.
- `*_done` and `*_rdata` are registered. `i_stall` and `d_stall` are combinational from `*_req` and the done flops.

## Structure
- Shared package `mips_mem_pkg`:
  - FSM state enum.
  - Owner encoding (OWN_I, OWN_D).
  - Byte-lane helper constants.
- Sub-module `mem_byte_format`: combinational.
  - Write side: builds `mem_be` and `mem_wdata` from addr, byte, we, wdata.
  - Read side: builds the extended load value from lane, signextend, rdata.
- The top level holds the FSM and the registers.

## Test plan
- Zero-wait fetch: `i_addr=0x100`, `mem_rdata=0xDEADBEEF` → `mem_addr=0x100`; `i_done` with `i_rdata=0xDEADBEEF` in cycle 3; `i_stall` high in cycles 0–2.
- Contention: `d_req` LW at 0x200 and `i_req` at 0x104 in the same cycle → D transaction first, then I; `i_done` 4 cycles after `d_done`.
- Byte ops:
  - SB `d_addr=0x203`, `d_wdata=0x5A` → `mem_be=4'b1000`, `mem_wdata=0x5A5A5A5A`.
  - LB at 0x201 with `mem_rdata=0x0000_8000` → `d_rdata=0xFFFFFF80`.
  - LBU at the same address → `d_rdata=0x00000080`.
- Wait states: `mem_ready` low for 2 cycles, then `mem_rvalid` 3 cycles after acceptance → `mem_req` held stable; done in cycle 7.
- Misaligned LW at 0x202 → `d_done` + `d_err` in cycle 1, `mem_req` never asserted.
- Reset mid-WAIT: `rst_n` low → all outputs 0 asynchronously. A subsequent `mem_rvalid` is ignored, and a new request then completes normally.
